// File: rtl/npu_pkg.sv
// Shared constants and encodings for the NPU load arbiter:
// default packet lengths, one-hot FSM states and the watchdog limit.
package npu_pkg;

  localparam int WEIGHT_LEN_DEF = 36;
  localparam int DATA_LEN_DEF   = 10;
  localparam int DATA_PKTS_DEF  = 3;
  localparam int TIMEOUT_LIMIT  = 1023;
  localparam int TIMEOUT_CNT_W  = 16;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_SOP      = 5'b00010,
    ST_BEAT     = 5'b00100,
    ST_CHECK    = 5'b01000,
    ST_WAIT_NPU = 5'b10000
  } state_t;

  typedef enum logic {
    SRC_W = 1'b0,
    SRC_D = 1'b1
  } src_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/npu_load_arbiter_if.sv
// Source/sink handshake bundle for the NPU load arbiter. The master modport
// is the arbiter side; the slave modport is the sources plus the NPU.
interface npu_load_arbiter_if;

  logic req_w;
  logic req_d;
  logic beat_vld_w;
  logic beat_vld_d;
  logic gnt_w;
  logic gnt_d;
  logic wr_sop_weight;
  logic wr_vld_weight;
  logic wr_eop_weight;
  logic wr_sop_data;
  logic wr_vld_data;
  logic wr_eop_data;
  logic err_weight;
  logic err_data;
  logic save_finish;
  logic busy;
  logic timeout;

  modport master (
    input  req_w, req_d, beat_vld_w, beat_vld_d, err_weight, err_data, save_finish,
    output gnt_w, gnt_d, wr_sop_weight, wr_vld_weight, wr_eop_weight,
           wr_sop_data, wr_vld_data, wr_eop_data, busy, timeout
  );

  modport slave (
    output req_w, req_d, beat_vld_w, beat_vld_d, err_weight, err_data, save_finish,
    input  gnt_w, gnt_d, wr_sop_weight, wr_vld_weight, wr_eop_weight,
           wr_sop_data, wr_vld_data, wr_eop_data, busy, timeout
  );

endinterface

// File: rtl/npu_rr_arbiter.sv
// Two-way round-robin arbiter with eligibility masking. Bit 0 is weight,
// bit 1 is data; weight holds priority out of reset.
module npu_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] elig,
  input  logic       update,
  output logic [1:0] gnt
);

  logic [1:0] cand;
  logic       prio_w_reg;

  assign cand = req & elig;

  always_comb begin
    gnt = 2'b00;
    if (cand == 2'b11) begin
      gnt = prio_w_reg ? 2'b01 : 2'b10;
    end else begin
      gnt = cand;
    end
  end

  // Priority goes to whichever source did not win the last grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_w_reg <= 1'b1;
    end else if (update && (gnt != 2'b00)) begin
      prio_w_reg <= gnt[1];
    end
  end

endmodule

// File: rtl/npu_load_arbiter.sv
// Arbitrates weight and data packet sources onto their NPU write channels,
// one round = one weight packet + DATA_PKTS data packets, then waits for the
// NPU. Define NPU_LOAD_ARB_TIMEOUT_EN to add the WAIT_NPU watchdog.
module npu_load_arbiter
  import npu_pkg::*;
#(
  parameter int WEIGHT_LEN = WEIGHT_LEN_DEF,
  parameter int DATA_LEN   = DATA_LEN_DEF,
  parameter int DATA_PKTS  = DATA_PKTS_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  npu_load_arbiter_if.master  bus
);

  localparam int BEAT_W = $clog2(max_int(WEIGHT_LEN, DATA_LEN) + 1);
  localparam int PKT_W  = $clog2(DATA_PKTS + 1);
  localparam logic [BEAT_W-1:0] W_LAST = BEAT_W'(WEIGHT_LEN - 1);
  localparam logic [BEAT_W-1:0] D_LAST = BEAT_W'(DATA_LEN - 1);
  localparam logic [PKT_W-1:0]  D_FULL = PKT_W'(DATA_PKTS);

  state_t             state_reg;
  src_t               owner_reg;
  logic               gnt_w_reg;
  logic               gnt_d_reg;
  logic               w_done_reg;
  logic [PKT_W-1:0]   d_cnt_reg;
  logic [BEAT_W-1:0]  beat_cnt_reg;

  logic [1:0]         elig;
  logic [1:0]         arb_gnt;
  logic               arb_update;
  logic               sel_vld;
  logic               sel_last;
  logic               sel_err;
  logic               beat_fire;
  logic               eop_fire;
  logic               w_done_next;
  logic [PKT_W-1:0]   d_cnt_next;

`ifdef NPU_LOAD_ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_CNT_W-1:0] WD_LAST = TIMEOUT_CNT_W'(TIMEOUT_LIMIT - 1);
  logic [TIMEOUT_CNT_W-1:0] wd_cnt_reg;
  logic                     timeout_reg;
`endif

  assign elig       = {(d_cnt_reg < D_FULL), ~w_done_reg};
  assign arb_update = (state_reg == ST_IDLE);

  npu_rr_arbiter u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({bus.req_d, bus.req_w}),
    .elig   (elig),
    .update (arb_update),
    .gnt    (arb_gnt)
  );

  assign sel_vld   = (owner_reg == SRC_W) ? bus.beat_vld_w : bus.beat_vld_d;
  assign sel_last  = (beat_cnt_reg == ((owner_reg == SRC_W) ? W_LAST : D_LAST));
  assign sel_err   = (owner_reg == SRC_W) ? bus.err_weight : bus.err_data;
  assign beat_fire = (state_reg == ST_BEAT) & sel_vld;
  assign eop_fire  = beat_fire & sel_last;

  // A packet flagged with a length error is not counted, so the source resends it
  always_comb begin
    w_done_next = w_done_reg;
    d_cnt_next  = d_cnt_reg;
    if (!sel_err) begin
      if (owner_reg == SRC_W) begin
        w_done_next = 1'b1;
      end else begin
        d_cnt_next = d_cnt_reg + PKT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      owner_reg    <= SRC_W;
      gnt_w_reg    <= 1'b0;
      gnt_d_reg    <= 1'b0;
      w_done_reg   <= 1'b0;
      d_cnt_reg    <= '0;
      beat_cnt_reg <= '0;
`ifdef NPU_LOAD_ARB_TIMEOUT_EN
      wd_cnt_reg   <= '0;
      timeout_reg  <= 1'b0;
`endif
    end else begin
`ifdef NPU_LOAD_ARB_TIMEOUT_EN
      timeout_reg <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (arb_gnt != 2'b00) begin
            owner_reg    <= arb_gnt[1] ? SRC_D : SRC_W;
            gnt_w_reg    <= arb_gnt[0];
            gnt_d_reg    <= arb_gnt[1];
            beat_cnt_reg <= '0;
            state_reg    <= ST_SOP;
          end
        end
        ST_SOP: begin
          state_reg <= ST_BEAT;
        end
        ST_BEAT: begin
          if (beat_fire) begin
            if (sel_last) begin
              beat_cnt_reg <= '0;
              gnt_w_reg    <= 1'b0;
              gnt_d_reg    <= 1'b0;
              state_reg    <= ST_CHECK;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
            end
          end
        end
        ST_CHECK: begin
          w_done_reg <= w_done_next;
          d_cnt_reg  <= d_cnt_next;
          state_reg  <= (w_done_next && (d_cnt_next == D_FULL)) ? ST_WAIT_NPU : ST_IDLE;
`ifdef NPU_LOAD_ARB_TIMEOUT_EN
          wd_cnt_reg <= '0;
`endif
        end
        ST_WAIT_NPU: begin
          if (bus.save_finish) begin
            w_done_reg   <= 1'b0;
            d_cnt_reg    <= '0;
            beat_cnt_reg <= '0;
            state_reg    <= ST_IDLE;
          end
`ifdef NPU_LOAD_ARB_TIMEOUT_EN
          else if (wd_cnt_reg == WD_LAST) begin
            timeout_reg  <= 1'b1;
            w_done_reg   <= 1'b0;
            d_cnt_reg    <= '0;
            beat_cnt_reg <= '0;
            state_reg    <= ST_IDLE;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + TIMEOUT_CNT_W'(1);
          end
`endif
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Beats pass straight through while in BEAT; outputs fall to 0 as soon as state is IDLE
  assign bus.gnt_w         = gnt_w_reg;
  assign bus.gnt_d         = gnt_d_reg;
  assign bus.wr_sop_weight = (state_reg == ST_SOP) & (owner_reg == SRC_W);
  assign bus.wr_vld_weight = beat_fire & (owner_reg == SRC_W);
  assign bus.wr_eop_weight = eop_fire & (owner_reg == SRC_W);
  assign bus.wr_sop_data   = (state_reg == ST_SOP) & (owner_reg == SRC_D);
  assign bus.wr_vld_data   = beat_fire & (owner_reg == SRC_D);
  assign bus.wr_eop_data   = eop_fire & (owner_reg == SRC_D);
  assign bus.busy          = (state_reg != ST_IDLE);

`ifdef NPU_LOAD_ARB_TIMEOUT_EN
  assign bus.timeout = timeout_reg;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule
